// File: rtl/rng_pkg.sv
// Shared definitions for the multi-stream multiply-with-carry RNG.
//   - MWC multiplier constants for the z and w halves of the state
//   - register index enum for the peripheral-bus register map
//   - controller FSM state enum
//   - mwc_step: one multiply-with-carry update of a 32-bit state word
package rng_pkg;

    localparam logic [15:0] MWC_MUL_Z = 16'd36969;
    localparam logic [15:0] MWC_MUL_W = 16'd18000;

    typedef enum logic [2:0] {
        REG_DATA   = 3'd0,
        REG_SEL    = 3'd1,
        REG_SEED_Z = 3'd2,
        REG_SEED_W = 3'd3,
        REG_CTRL   = 3'd4
    } rng_reg_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD,
        ST_CALC,
        ST_ACK
    } rng_state_e;

    // s' = mul * s[15:0] + s[31:16]; cannot exceed 32 bits for 16-bit operands.
    function automatic logic [31:0] mwc_step(input logic [31:0] s, input logic [15:0] mul);
        logic [31:0] w_prod;
        w_prod = {16'h0, s[15:0]} * {16'h0, mul};
        return w_prod + {16'h0, s[31:16]};
    endfunction

endpackage

// File: rtl/random_mwc_multi_if.sv
// Peripheral-bus connection of the RNG slave.
//   cs_i    slave select, held high by the master until ack_o
//   we_i    1 = write
//   adr_i   register index (byte address bits [4:2])
//   dat_i   write data
//   dat_o   read data, valid while ack_o=1, else 0
//   ack_o   one-cycle transfer acknowledge
//   busy_o  high while the stream initialisation walk runs
interface random_mwc_multi_if;

    logic        cs_i;
    logic        we_i;
    logic [2:0]  adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        busy_o;

    modport master (
        output cs_i, we_i, adr_i, dat_i,
        input  dat_o, ack_o, busy_o
    );

    modport slave (
        input  cs_i, we_i, adr_i, dat_i,
        output dat_o, ack_o, busy_o
    );

endinterface

// File: rtl/rng_state_ram.sv
// Per-stream z/w state store: 2**AW x 64-bit simple dual-port RAM.
//   clk_i       clock
//   i_we_z      write enable for the z lane (bits 31:0)
//   i_we_w      write enable for the w lane (bits 63:32)
//   i_waddr     write address
//   i_wdata_z   z lane write data
//   i_wdata_w   w lane write data
//   i_raddr     read address
//   o_rdata_z   registered z lane read data
//   o_rdata_w   registered w lane read data
module rng_state_ram #(
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          i_we_z,
    input  logic          i_we_w,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata_z,
    input  logic [31:0]   i_wdata_w,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata_z,
    output logic [31:0]   o_rdata_w
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [63:0] r_mem [DEPTH];
    logic [63:0] r_rdata;

    // No reset: contents are rebuilt by the controller's init walk.
    always_ff @(posedge clk_i) begin
        if (i_we_z) r_mem[i_waddr][31:0]  <= i_wdata_z;
        if (i_we_w) r_mem[i_waddr][63:32] <= i_wdata_w;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata_z = r_rdata[31:0];
    assign o_rdata_w = r_rdata[63:32];

endmodule

// File: rtl/random_mwc_multi.sv
// Multi-stream Marsaglia multiply-with-carry RNG, peripheral-bus slave.
// Every stream's z/w state lives in one block RAM; the controller walks
// all streams after reset (or on command) to seed them, then serves
// register accesses with a fixed three-clock acknowledge latency.
//   clk_i   clock
//   rst_i   asynchronous reset, active-high
//   bus     slave side of random_mwc_multi_if (cs/we/adr/dat, ack, busy)
module random_mwc_multi
    import rng_pkg::*;
#(
    parameter int unsigned STREAM_AW = 10,
    parameter logic [31:0] SEED_Z    = 32'd17,
    parameter logic [31:0] SEED_W    = 32'd3,
    parameter bit          AUTO_ADV  = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    random_mwc_multi_if.slave  bus
);

    rng_state_e           r_state;
    rng_state_e           w_next;

    logic [STREAM_AW-1:0] r_idx;
    logic [STREAM_AW-1:0] r_stream;
    logic [STREAM_AW-1:0] r_sel;
    logic                 r_we;
    logic [2:0]           r_adr;
    logic [31:0]          r_dat;
    logic [31:0]          r_rdata;
    logic [31:0]          r_z_nxt;
    logic [31:0]          r_w_nxt;

    logic [31:0]          w_ram_z;
    logic [31:0]          w_ram_w;
    logic                 w_we_z;
    logic                 w_we_w;
    logic [STREAM_AW-1:0] w_waddr;
    logic [31:0]          w_wdata_z;
    logic [31:0]          w_wdata_w;
    logic [31:0]          w_rdword;
    logic                 w_busy;
    logic                 w_ack;
    logic                 w_advance;
    logic                 w_restart;

    assign w_advance = (r_adr == REG_DATA) && (r_we || AUTO_ADV);
    assign w_restart = r_we && (r_adr == REG_CTRL) && r_dat[0];

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_INIT;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT: if (r_idx == '1) w_next = ST_IDLE;
            ST_IDLE: if (bus.cs_i) w_next = ST_RD;
            ST_RD:   w_next = ST_CALC;
            ST_CALC: w_next = ST_ACK;
            ST_ACK:  w_next = w_restart ? ST_INIT : ST_IDLE;
            default: w_next = ST_INIT;
        endcase
    end

    // FSM outputs: bus status and RAM write port
    always_comb begin
        w_busy    = (r_state == ST_INIT);
        w_ack     = (r_state == ST_ACK);
        w_we_z    = 1'b0;
        w_we_w    = 1'b0;
        w_waddr   = r_sel;
        w_wdata_z = r_z_nxt;
        w_wdata_w = r_w_nxt;
        case (r_state)
            ST_INIT: begin
                w_we_z    = 1'b1;
                w_we_w    = 1'b1;
                w_waddr   = r_idx;
                w_wdata_z = SEED_Z + 32'(r_idx);
                w_wdata_w = SEED_W + 32'(r_idx);
            end
            ST_ACK: begin
                if (w_advance) begin
                    w_we_z = 1'b1;
                    w_we_w = 1'b1;
                end else if (r_we && (r_adr == REG_SEED_Z)) begin
                    // A zero seed would lock the generator at zero.
                    w_we_z    = 1'b1;
                    w_wdata_z = (r_dat == '0) ? SEED_Z : r_dat;
                end else if (r_we && (r_adr == REG_SEED_W)) begin
                    w_we_w    = 1'b1;
                    w_wdata_w = (r_dat == '0) ? SEED_W : r_dat;
                end
            end
            default: ;
        endcase
    end

    // Read word, formed in CALC while the RAM output is valid
    always_comb begin
        w_rdword = '0;
        if (!r_we) begin
            case (r_adr)
                REG_DATA: w_rdword = {w_ram_z[15:0], 16'h0} + w_ram_w;
                REG_SEL:  w_rdword = 32'(r_stream);
                REG_CTRL: w_rdword = {31'b0, w_busy};
                default:  w_rdword = '0;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx    <= '0;
            r_stream <= '0;
            r_sel    <= '0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_rdata  <= '0;
            r_z_nxt  <= '0;
            r_w_nxt  <= '0;
        end else begin
            case (r_state)
                // Wraps to 0 on the last stream, ready for the next walk.
                ST_INIT: r_idx <= r_idx + 1'b1;
                ST_IDLE: begin
                    if (bus.cs_i) begin
                        r_we  <= bus.we_i;
                        r_adr <= bus.adr_i;
                        r_dat <= bus.dat_i;
                        r_sel <= r_stream;
                    end
                end
                ST_CALC: begin
                    r_rdata <= w_rdword;
                    r_z_nxt <= mwc_step(w_ram_z, MWC_MUL_Z);
                    r_w_nxt <= mwc_step(w_ram_w, MWC_MUL_W);
                end
                // Select update lands after the current access has used r_sel.
                ST_ACK: if (r_we && (r_adr == REG_SEL)) r_stream <= r_dat[STREAM_AW-1:0];
                default: ;
            endcase
        end
    end

    rng_state_ram #(
        .AW (STREAM_AW)
    ) u_ram (
        .clk_i     (clk_i),
        .i_we_z    (w_we_z),
        .i_we_w    (w_we_w),
        .i_waddr   (w_waddr),
        .i_wdata_z (w_wdata_z),
        .i_wdata_w (w_wdata_w),
        .i_raddr   (r_sel),
        .o_rdata_z (w_ram_z),
        .o_rdata_w (w_ram_w)
    );

    assign bus.ack_o  = w_ack;
    assign bus.dat_o  = w_ack ? r_rdata : '0;
    assign bus.busy_o = w_busy;

endmodule

// File: tb/tb_random_mwc_multi.sv
// Directed self-checking bench for random_mwc_multi.
// dut: default parameters (1024 streams, no auto-advance).
// dut_aa: 16 streams with auto-advance on reads of register 0.
module tb_random_mwc_multi;

    localparam int unsigned N_MAIN = 1024;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    random_mwc_multi_if bif ();
    random_mwc_multi_if bif_aa ();

    random_mwc_multi #(
        .STREAM_AW (10),
        .SEED_Z    (32'd17),
        .SEED_W    (32'd3),
        .AUTO_ADV  (1'b0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    random_mwc_multi #(
        .STREAM_AW (4),
        .SEED_Z    (32'd17),
        .SEED_W    (32'd3),
        .AUTO_ADV  (1'b1)
    ) dut_aa (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif_aa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One bus transfer, started at a negedge; returns at a negedge one clock after ack.
    task automatic xfer(input bit aa, input logic we, input logic [2:0] adr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output logic ack_after);
        rd = '0;
        lat = 0;
        if (aa) begin
            bif_aa.cs_i = 1'b1; bif_aa.we_i = we; bif_aa.adr_i = adr; bif_aa.dat_i = wd;
        end else begin
            bif.cs_i = 1'b1; bif.we_i = we; bif.adr_i = adr; bif.dat_i = wd;
        end
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); @(negedge clk);
            if ((aa ? bif_aa.ack_o : bif.ack_o) === 1'b1) begin
                lat = k;
                rd = aa ? bif_aa.dat_o : bif.dat_o;
                break;
            end
        end
        bif.cs_i = 1'b0;
        bif_aa.cs_i = 1'b0;
        if (lat == 0) begin
            n_cmp++; n_err++;
            $display("FAIL xfer_timeout adr=%0d got no ack within 16 clocks, required ack", adr);
        end
        @(posedge clk); @(negedge clk);
        ack_after = aa ? bif_aa.ack_o : bif.ack_o;
    endtask

    // Counts negedge samples with busy_o high until it falls.
    task automatic wait_idle(input bit aa, output int cnt);
        cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            if ((aa ? bif_aa.busy_o : bif.busy_o) !== 1'b1) break;
            cnt++;
            @(posedge clk); @(negedge clk);
        end
        if ((aa ? bif_aa.busy_o : bif.busy_o) !== 1'b0) begin
            n_cmp++; n_err++;
            $display("FAIL busy_timeout busy=%b required 0", aa ? bif_aa.busy_o : bif.busy_o);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int          lat;
        logic        aft;
        int          cnt;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (bif.ack_o !== 1'b0)  begin n_err++; $display("FAIL rst_ack got=%b exp=0", bif.ack_o); end
        n_cmp++; if (bif.dat_o !== 32'h0) begin n_err++; $display("FAIL rst_dat got=%h exp=00000000", bif.dat_o); end
        n_cmp++; if (bif.busy_o !== 1'b1) begin n_err++; $display("FAIL rst_busy got=%b exp=1", bif.busy_o); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_idle(1'b0, cnt);
        wait_idle(1'b1, cnt);
        n_cmp++; if (bif.dat_o !== 32'h0) begin n_err++; $display("FAIL idle_dat got=%h exp=00000000", bif.dat_o); end
        xfer(1'b0, 1'b0, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h00110003) begin n_err++; $display("FAIL s0_first got=%h exp=00110003", rd); end
        n_cmp++; if (lat != 3)            begin n_err++; $display("FAIL s0_first_lat got=%0d exp=3", lat); end
        n_cmp++; if (aft !== 1'b0)        begin n_err++; $display("FAIL s0_first_ackw got=%b exp=0", aft); end
    endtask

    task automatic test_advance();
        logic [31:0] rd;
        int          lat;
        logic        aft;
        xfer(1'b0, 1'b1, 3'd0, 32'hDEAD_BEEF, rd, lat, aft);
        n_cmp++; if (lat != 3)     begin n_err++; $display("FAIL adv_lat got=%0d exp=3", lat); end
        n_cmp++; if (aft !== 1'b0) begin n_err++; $display("FAIL adv_ackw got=%b exp=0", aft); end
        xfer(1'b0, 1'b0, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h96F9D2F0) begin n_err++; $display("FAIL s0_adv got=%h exp=96F9D2F0", rd); end
    endtask

    task automatic test_stream_select();
        logic [31:0] rd;
        int          lat;
        logic        aft;
        xfer(1'b0, 1'b1, 3'd1, 32'd5, rd, lat, aft);
        xfer(1'b0, 1'b0, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h00160008) begin n_err++; $display("FAIL s5_read got=%h exp=00160008", rd); end
        n_cmp++; if (lat != 3)            begin n_err++; $display("FAIL s5_lat got=%0d exp=3", lat); end
        xfer(1'b0, 1'b0, 3'd1, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h00000005) begin n_err++; $display("FAIL sel_read got=%h exp=00000005", rd); end
        xfer(1'b0, 1'b1, 3'd0, 32'h0, rd, lat, aft);
        xfer(1'b0, 1'b1, 3'd1, 32'hFFFF_FC05, rd, lat, aft);
        xfer(1'b0, 1'b0, 3'd1, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h00000005) begin n_err++; $display("FAIL sel_upper got=%h exp=00000005", rd); end
        xfer(1'b0, 1'b1, 3'd1, 32'd0, rd, lat, aft);
        xfer(1'b0, 1'b0, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h96F9D2F0) begin n_err++; $display("FAIL s0_isolated got=%h exp=96F9D2F0", rd); end
    endtask

    task automatic test_zero_seed();
        logic [31:0] rd;
        int          lat;
        logic        aft;
        xfer(1'b0, 1'b1, 3'd1, 32'd2, rd, lat, aft);
        xfer(1'b0, 1'b0, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h00130005) begin n_err++; $display("FAIL s2_init got=%h exp=00130005", rd); end
        xfer(1'b0, 1'b1, 3'd2, 32'h0, rd, lat, aft);
        xfer(1'b0, 1'b1, 3'd3, 32'h0, rd, lat, aft);
        xfer(1'b0, 1'b0, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h00110003) begin n_err++; $display("FAIL s2_zero_seed got=%h exp=00110003", rd); end
        xfer(1'b0, 1'b1, 3'd2, 32'h0000_0020, rd, lat, aft);
        xfer(1'b0, 1'b0, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h00200003) begin n_err++; $display("FAIL s2_seed_z got=%h exp=00200003", rd); end
        xfer(1'b0, 1'b1, 3'd3, 32'h0000_0007, rd, lat, aft);
        xfer(1'b0, 1'b0, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h00200007) begin n_err++; $display("FAIL s2_seed_w got=%h exp=00200007", rd); end
        xfer(1'b0, 1'b0, 3'd2, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL seed_rd got=%h exp=00000000", rd); end
        xfer(1'b0, 1'b0, 3'd4, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL status_rd got=%h exp=00000000", rd); end
        xfer(1'b0, 1'b0, 3'd5, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL reg5_rd got=%h exp=00000000", rd); end
        n_cmp++; if (lat != 3)     begin n_err++; $display("FAIL reg5_lat got=%0d exp=3", lat); end
        xfer(1'b0, 1'b1, 3'd6, 32'hFFFF_FFFF, rd, lat, aft);
        n_cmp++; if (lat != 3)     begin n_err++; $display("FAIL reg6_wr_lat got=%0d exp=3", lat); end
    endtask

    task automatic test_auto_adv();
        logic [31:0] rd;
        int          lat;
        logic        aft;
        xfer(1'b1, 1'b0, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h00110003) begin n_err++; $display("FAIL aa_read1 got=%h exp=00110003", rd); end
        n_cmp++; if (lat != 3)            begin n_err++; $display("FAIL aa_lat got=%0d exp=3", lat); end
        xfer(1'b1, 1'b0, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h96F9D2F0) begin n_err++; $display("FAIL aa_read2 got=%h exp=96F9D2F0", rd); end
    endtask

    task automatic test_init_block();
        logic [31:0] rd;
        int          lat;
        logic        aft;
        int          busy_cnt;
        int          early;
        xfer(1'b0, 1'b1, 3'd1, 32'd0, rd, lat, aft);
        xfer(1'b0, 1'b1, 3'd4, 32'd1, rd, lat, aft);
        n_cmp++; if (bif.busy_o !== 1'b1) begin n_err++; $display("FAIL restart_busy got=%b exp=1", bif.busy_o); end
        // Read issued while the walk is still running.
        bif.cs_i = 1'b1; bif.we_i = 1'b0; bif.adr_i = 3'd0; bif.dat_i = 32'h0;
        busy_cnt = 0;
        early = 0;
        for (int i = 0; i < 5000; i++) begin
            if (bif.busy_o !== 1'b1) break;
            if (bif.ack_o === 1'b1) early++;
            busy_cnt++;
            @(posedge clk); @(negedge clk);
        end
        lat = 0;
        rd = '0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); @(negedge clk);
            if (bif.ack_o === 1'b1) begin lat = k; rd = bif.dat_o; break; end
        end
        bif.cs_i = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (busy_cnt != N_MAIN) begin n_err++; $display("FAIL restart_len got=%0d exp=%0d", busy_cnt, N_MAIN); end
        n_cmp++; if (early != 0)         begin n_err++; $display("FAIL ack_in_init got=%0d exp=0", early); end
        n_cmp++; if (lat != 3)           begin n_err++; $display("FAIL post_init_lat got=%0d exp=3", lat); end
        n_cmp++; if (rd !== 32'h00110003) begin n_err++; $display("FAIL post_init_s0 got=%h exp=00110003", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int          lat;
        logic        aft;
        logic        seen;
        xfer(1'b0, 1'b1, 3'd1, 32'd7, rd, lat, aft);
        bif.cs_i = 1'b1; bif.we_i = 1'b1; bif.adr_i = 3'd0; bif.dat_i = 32'h0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (bif.ack_o !== 1'b0)  begin n_err++; $display("FAIL midrst_ack got=%b exp=0", bif.ack_o); end
        n_cmp++; if (bif.dat_o !== 32'h0) begin n_err++; $display("FAIL midrst_dat got=%h exp=00000000", bif.dat_o); end
        n_cmp++; if (bif.busy_o !== 1'b1) begin n_err++; $display("FAIL midrst_busy got=%b exp=1", bif.busy_o); end
        bif.cs_i = 1'b0;
        seen = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); if (bif.ack_o === 1'b1) seen = 1'b1; end
        rst = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            if (bif.busy_o !== 1'b1) break;
            @(posedge clk); @(negedge clk);
            if (bif.ack_o === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0)       begin n_err++; $display("FAIL midrst_noack got=%b exp=0", seen); end
        n_cmp++; if (bif.busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_idle got=%b exp=0", bif.busy_o); end
        xfer(1'b0, 1'b0, 3'd1, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h0)        begin n_err++; $display("FAIL midrst_sel got=%h exp=00000000", rd); end
        xfer(1'b0, 1'b0, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h00110003) begin n_err++; $display("FAIL midrst_s0 got=%h exp=00110003", rd); end
        n_cmp++; if (lat != 3)            begin n_err++; $display("FAIL midrst_lat got=%0d exp=3", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int          lat;
        logic        aft;
        xfer(1'b0, 1'b1, 3'd0, 32'h0, rd, lat, aft);
        xfer(1'b0, 1'b1, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (lat != 3)     begin n_err++; $display("FAIL b2b_lat got=%0d exp=3", lat); end
        n_cmp++; if (aft !== 1'b0) begin n_err++; $display("FAIL b2b_ackw got=%b exp=0", aft); end
        xfer(1'b0, 1'b0, 3'd0, 32'h0, rd, lat, aft);
        n_cmp++; if (rd !== 32'h36198B00) begin n_err++; $display("FAIL b2b_read got=%h exp=36198B00", rd); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bif.cs_i = 1'b0;    bif.we_i = 1'b0;    bif.adr_i = 3'd0;    bif.dat_i = 32'h0;
        bif_aa.cs_i = 1'b0; bif_aa.we_i = 1'b0; bif_aa.adr_i = 3'd0; bif_aa.dat_i = 32'h0;
        test_reset();
        test_advance();
        test_stream_select();
        test_zero_seed();
        test_auto_adv();
        test_init_block();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
